// File: rtl/bit_serial_alu.sv
// Bit-serial ALU stage: consumes two operands LSB-first, one bit per clock,
// and streams the result LSB-first with final carry and zero flags.
//
// state  | meaning
// IDLE   | waiting for start; result outputs quiet, flags hold last operation
// RUN    | one operand bit pair consumed per cycle, result bit registered
// FINISH | last result bit on the output, done pulse, flags updated
module bit_serial_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       busy,
    output logic       res_bit,
    output logic       res_valid,
    output logic       done,
    output logic       carry_out,
    output logic       zero_out
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_shl;
    logic             r_zero;
    logic             r_busy;
    logic             r_res_bit;
    logic             r_res_valid;
    logic             r_done;
    logic             r_carry_out;
    logic             r_zero_out;

    logic             w_b;
    logic             w_bit;
    logic             w_carry;

    // Per-bit datapath: result bit and next carry for the current operand pair.
    // For SHL the carry register simply tracks the most recent A bit, so it
    // holds a[WIDTH-1] when the operation finishes.
    always_comb begin
        w_b     = (r_op == OP_SUB) ? ~b_bit : b_bit;
        w_bit   = a_bit;
        w_carry = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_bit   = a_bit ^ w_b ^ r_carry;
                w_carry = (a_bit & w_b) | (a_bit & r_carry) | (w_b & r_carry);
            end
            OP_AND:   w_bit = a_bit & b_bit;
            OP_OR:    w_bit = a_bit | b_bit;
            OP_XOR:   w_bit = a_bit ^ b_bit;
            OP_PASSB: w_bit = b_bit;
            OP_SHL: begin
                w_bit   = r_shl;
                w_carry = a_bit;
            end
            default:  w_bit = a_bit;
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= 3'b000;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_shl       <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_res_bit   <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
            r_zero_out  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_res_bit   <= w_bit;
                    r_res_valid <= 1'b1;
                    r_carry     <= w_carry;
                    r_shl       <= a_bit;
                    r_zero      <= r_zero & ~w_bit;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state     <= FINISH;
                        r_done      <= 1'b1;
                        r_carry_out <= w_carry;
                        r_zero_out  <= r_zero & ~w_bit;
                    end
                end
                FINISH: begin
                    r_res_bit   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_res_bit   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_done      <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_carry <= (op == OP_SUB);
                        r_shl   <= 1'b0;
                        r_zero  <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign res_bit   = r_res_bit;
    assign res_valid = r_res_valid;
    assign done      = r_done;
    assign carry_out = r_carry_out;
    assign zero_out  = r_zero_out;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed bench for bit_serial_alu: vector table plus busy/reset sequences.
module tb_bit_serial_alu;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic       a_bit;
    logic       b_bit;
    logic       busy;
    logic       res_bit;
    logic       res_valid;
    logic       done;
    logic       carry_out;
    logic       zero_out;

    int checks   = 0;
    int failures = 0;

    bit_serial_alu #(.WIDTH(8), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .res_bit   (res_bit),
        .res_valid (res_valid),
        .done      (done),
        .carry_out (carry_out),
        .zero_out  (zero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller must be at a negedge. Drives start in cycle T, streams operands in
    // T+1..T+W, checks per-cycle handshake, returns at the negedge of T+W+2.
    // inj_cyc > 0 raises start again in cycle T+inj_cyc (must be ignored).
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input int inj_cyc, output logic [7:0] res,
                          output logic c, output logic z, output int n_done);
        res    = 8'h00;
        c      = 1'b0;
        z      = 1'b0;
        n_done = 0;
        start  = 1'b1;
        op     = o;
        a_bit  = 1'b0;
        b_bit  = 1'b0;
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", cyc), 32'(busy), 32'(cyc <= W + 1));
            chk($sformatf("valid_c%0d", cyc), 32'(res_valid), 32'(cyc >= 2 && cyc <= W + 1));
            if (done) n_done++;
            if (res_valid) res[cyc-2] = res_bit;
            else if (res_bit !== 1'b0) chk("res_bit_idle", 32'(res_bit), 32'd0);
            if (cyc == W + 1) begin
                chk("done_last", 32'(done), 32'd1);
                c = carry_out;
                z = zero_out;
            end
            start = (cyc == inj_cyc);
            op    = 3'b111;
            a_bit = (cyc <= W) ? a[cyc-1] : 1'b0;
            b_bit = (cyc <= W) ? b[cyc-1] : 1'b0;
        end
    endtask

    vec_t       vecs[$];
    logic [7:0] r;
    logic       c;
    logic       z;
    int         nd;

    initial begin
        vecs.push_back('{3'b000, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0});
        vecs.push_back('{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{3'b001, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{3'b001, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0});
        vecs.push_back('{3'b001, 8'h55, 8'h55, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{3'b110, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{3'b110, 8'h40, 8'hFF, 8'h80, 1'b0, 1'b0});
        vecs.push_back('{3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0});
        vecs.push_back('{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0});
        vecs.push_back('{3'b011, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{3'b011, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{3'b101, 8'hFF, 8'h5A, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{3'b111, 8'hC3, 8'hFF, 8'hC3, 1'b0, 1'b0});

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a_bit = 1'b0;
        b_bit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_res",   32'(res_bit), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_zero",  32'(zero_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, c, z, nd);
            chk($sformatf("v%0d_res", i),   32'(r), 32'(vecs[i].res));
            chk($sformatf("v%0d_carry", i), 32'(c), 32'(vecs[i].c));
            chk($sformatf("v%0d_zero", i),  32'(z), 32'(vecs[i].z));
            chk($sformatf("v%0d_ndone", i), 32'(nd), 32'd1);
            start = 1'b0;
            @(negedge clk);
        end

        // start at T+3 while busy is ignored; back-to-back start at T+10 accepted
        run_op(3'b000, 8'h3C, 8'h0F, 3, r, c, z, nd);
        chk("ign_res",   32'(r), 32'h4B);
        chk("ign_ndone", 32'(nd), 32'd1);
        run_op(3'b001, 8'h20, 8'h10, 0, r, c, z, nd);
        chk("b2b_res",   32'(r), 32'h10);
        chk("b2b_carry", 32'(c), 32'd1);
        chk("b2b_ndone", 32'(nd), 32'd1);
        start = 1'b0;
        @(negedge clk);

        // reset in cycle T+4 of an ADD aborts it without a done pulse
        start = 1'b1;
        op    = 3'b000;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            a_bit = 1'b1;
            b_bit = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_done",  32'(done), 32'd0);
        nd = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort_quiet", 32'(nd), 32'd0);
        run_op(3'b000, 8'hFF, 8'h01, 0, r, c, z, nd);
        chk("fresh_res",   32'(r), 32'h00);
        chk("fresh_carry", 32'(c), 32'd1);
        chk("fresh_zero",  32'(z), 32'd1);
        chk("fresh_ndone", 32'(nd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
